// File: rtl/rocket_sim_pkg.sv
// -----------------------------------------------------------------------------
// rocket_sim_pkg
// Shared definitions for the flight-simulation datapath.
//   N                 : data width of fixed-point quantities
//   SAMPLE_CYCLES     : clocks per simulated second
//   FIXED_POINT_SCALE : 1e9 fixed-point units per physical unit
//   state_t           : differentiator sequencing states
//   sat_sub()         : a - b on unsigned N-bit operands, clamped to the
//                       signed N-bit range, with a saturation flag
// -----------------------------------------------------------------------------
package rocket_sim_pkg;

   localparam int N             = 64;
   localparam int SAMPLE_CYCLES = 50;

   localparam logic [N-1:0] FIXED_POINT_SCALE = 64'd1_000_000_000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   typedef struct packed {
      logic [N-1:0] value;
      logic         saturated;
   } sat_result_t;

   // The N+1-bit difference of two unsigned values spans -(2^N-1)..(2^N-1).
   // It fits in N signed bits exactly when its top two bits agree.
   function automatic sat_result_t sat_sub(input logic [N-1:0] a,
                                           input logic [N-1:0] b);
      logic [N:0]  wide;
      sat_result_t r;
      wide        = {1'b0, a} - {1'b0, b};
      r.saturated = wide[N] ^ wide[N-1];
      if (!r.saturated)
         r.value = wide[N-1:0];
      else if (!wide[N])
         r.value = {1'b0, {(N-1){1'b1}}};
      else
         r.value = {1'b1, {(N-1){1'b0}}};
      return r;
   endfunction

endpackage

// File: rtl/diff_ring_average.sv
// -----------------------------------------------------------------------------
// diff_ring_average
// Moving-window accumulator over the last AVG_DEPTH differences.
//   clk, resetb : clock, asynchronous active-low reset
//   push        : store diff and update the running sum
//   clear       : synchronously empty the window (ring, pointer, sum, fill)
//   diff        : signed N-bit difference to insert
//   sum         : signed N+AVG_SHIFT-bit sum of the window contents
//   full        : window holds AVG_DEPTH differences
// -----------------------------------------------------------------------------
module diff_ring_average
   import rocket_sim_pkg::*;
#(
   parameter int AVG_DEPTH = 4,
   parameter int AVG_SHIFT = 2
) (
   input  logic                   clk,
   input  logic                   resetb,
   input  logic                   push,
   input  logic                   clear,
   input  logic [N-1:0]           diff,
   output logic [N+AVG_SHIFT-1:0] sum,
   output logic                   full
);

   localparam int SUM_W  = N + AVG_SHIFT;
   localparam int PTR_W  = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
   localparam int FILL_W = $clog2(AVG_DEPTH + 1);

   logic [N-1:0]            ring [AVG_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [FILL_W-1:0]       fill_count;
   logic signed [SUM_W-1:0] sum_q;
   logic signed [SUM_W-1:0] diff_ext;
   logic signed [SUM_W-1:0] old_ext;

   // Sign-extend both the incoming and the outgoing entries; the window sum
   // of AVG_DEPTH N-bit values needs exactly AVG_SHIFT guard bits.
   assign diff_ext = SUM_W'($signed(diff));
   assign old_ext  = SUM_W'($signed(ring[wr_ptr]));

   // NOTE: the ring is small and must read as zero after reset so the first
   // AVG_DEPTH pushes subtract nothing; it therefore sits in the reset branch.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < AVG_DEPTH; i++) ring[i] <= '0;
         wr_ptr     <= '0;
         fill_count <= '0;
         sum_q      <= '0;
      end else if (clear) begin
         for (int i = 0; i < AVG_DEPTH; i++) ring[i] <= '0;
         wr_ptr     <= '0;
         fill_count <= '0;
         sum_q      <= '0;
      end else if (push) begin
         ring[wr_ptr] <= diff;
         sum_q        <= sum_q + diff_ext - old_ext;
         wr_ptr       <= (wr_ptr == PTR_W'(AVG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (fill_count != FILL_W'(AVG_DEPTH))
            fill_count <= fill_count + 1'b1;
      end
   end

   assign sum  = sum_q;
   assign full = (fill_count == FILL_W'(AVG_DEPTH));

endmodule

// File: rtl/numerical_differentiator.sv
// -----------------------------------------------------------------------------
// numerical_differentiator
// Converts a sampled fixed-point quantity into its per-simulated-second rate:
// one finite difference every SAMPLE_CYCLES clocks, averaged over AVG_DEPTH.
//   clk, resetb            : clock, asynchronous active-low reset
//   start_differentiation  : level enable; low returns to IDLE
//   signal_input [N]       : unsigned fixed-point sample source
//   derivative   [N]       : signed averaged difference per simulated second
//   derivative_valid       : derivative holds a full-window average
//   sample_tick            : one-cycle pulse after each sampling edge
//   overflow               : sticky, a difference saturated this run
// AVG_DEPTH must be a power of two in 1..16 and AVG_SHIFT its log2.
// -----------------------------------------------------------------------------
module numerical_differentiator
   import rocket_sim_pkg::*;
#(
   parameter int AVG_DEPTH = 4,
   parameter int AVG_SHIFT = 2
) (
   input  logic         clk,
   input  logic         resetb,
   input  logic         start_differentiation,
   input  logic [N-1:0] signal_input,
   output logic [N-1:0] derivative,
   output logic         derivative_valid,
   output logic         sample_tick,
   output logic         overflow
);

   localparam int SUM_W = N + AVG_SHIFT;
   localparam int CNT_W = $clog2(SAMPLE_CYCLES);

   state_t                  state;
   logic [CNT_W-1:0]        cycle_count;
   logic [N-1:0]            prev_sample;
   logic                    tick;
   logic                    ring_clear;
   logic                    ring_full;
   sat_result_t             diff_res;
   logic signed [SUM_W-1:0] ring_sum;

   // NOTE: every combinational output gets a default before any condition,
   // so no path can leave it unassigned and infer a latch.
   always_comb begin
      tick       = 1'b0;
      ring_clear = 1'b0;
      if (state != IDLE && start_differentiation &&
          cycle_count == CNT_W'(SAMPLE_CYCLES - 1))
         tick = 1'b1;
      if (state == IDLE || !start_differentiation)
         ring_clear = 1'b1;
      diff_res = sat_sub(signal_input, prev_sample);
   end

   diff_ring_average #(
      .AVG_DEPTH (AVG_DEPTH),
      .AVG_SHIFT (AVG_SHIFT)
   ) u_ring (
      .clk    (clk),
      .resetb (resetb),
      .push   (tick),
      .clear  (ring_clear),
      .diff   (diff_res.value),
      .sum    (ring_sum),
      .full   (ring_full)
   );

   // NOTE: all state here is sequential and uses non-blocking assignments so
   // every register samples pre-edge values, regardless of statement order.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state            <= IDLE;
         cycle_count      <= '0;
         prev_sample      <= '0;
         derivative       <= '0;
         derivative_valid <= 1'b0;
         sample_tick      <= 1'b0;
         overflow         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               sample_tick <= 1'b0;
               if (start_differentiation) begin
                  prev_sample <= signal_input;
                  sample_tick <= 1'b1;
                  cycle_count <= '0;
                  overflow    <= 1'b0;
                  state       <= FILL;
               end
            end

            FILL, RUN: begin
               if (!start_differentiation) begin
                  // overflow is deliberately kept for post-run inspection.
                  state            <= IDLE;
                  cycle_count      <= '0;
                  derivative       <= '0;
                  derivative_valid <= 1'b0;
                  sample_tick      <= 1'b0;
               end else begin
                  sample_tick <= tick;
                  cycle_count <= tick ? '0 : cycle_count + 1'b1;
                  if (tick) begin
                     prev_sample <= signal_input;
                     if (diff_res.saturated)
                        overflow <= 1'b1;
                  end
                  // The ring sum settles on the tick edge; the cycle after,
                  // sample_tick is high and the average is ready to register.
                  if (sample_tick && ring_full) begin
                     state            <= RUN;
                     derivative       <= N'(ring_sum >>> AVG_SHIFT);
                     derivative_valid <= 1'b1;
                  end
               end
            end

            default: begin
               state       <= IDLE;
               sample_tick <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_numerical_differentiator.sv
// -----------------------------------------------------------------------------
// tb_numerical_differentiator
// Scoreboarded bench: the driver predicts each sample_tick (cycle, derivative,
// valid, overflow) from an arithmetic model of the window average and queues
// it; an independent monitor pops an entry on every observed sample_tick.
// -----------------------------------------------------------------------------
module tb_numerical_differentiator;
   import rocket_sim_pkg::*;

   localparam int DEPTH = 4;
   localparam logic signed [65:0] MAX_POS = (66'sd1 <<< 63) - 66'sd1;
   localparam logic signed [65:0] MAX_NEG = -(66'sd1 <<< 63);
   localparam logic signed [67:0] DEPTH_S = 68'sd4;

   logic         clk = 1'b0;
   logic         resetb = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] sig = '0;
   logic [N-1:0] derivative;
   logic         derivative_valid;
   logic         sample_tick;
   logic         overflow;

   numerical_differentiator #(.AVG_DEPTH(DEPTH), .AVG_SHIFT(2)) dut (
      .clk                   (clk),
      .resetb                (resetb),
      .start_differentiation (start),
      .signal_input          (sig),
      .derivative            (derivative),
      .derivative_valid      (derivative_valid),
      .sample_tick           (sample_tick),
      .overflow              (overflow)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int unsigned  cyc;
      logic [N-1:0] deriv;
      logic         valid;
      logic         ovf;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [N-1:0] actual,
                        input logic [N-1:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------- reference model (window of saturated differences) -----
   logic [N-1:0]       m_prev;
   logic signed [65:0] m_diffs[$];
   logic               m_ovf;

   task automatic model_tick(input logic [N-1:0] v, output logic [N-1:0] d_out,
                             output logic valid_out);
      logic signed [65:0] d;
      logic signed [67:0] s, q;
      d = $signed({2'b00, v}) - $signed({2'b00, m_prev});
      if (d > MAX_POS) begin d = MAX_POS; m_ovf = 1'b1; end
      else if (d < MAX_NEG) begin d = MAX_NEG; m_ovf = 1'b1; end
      m_diffs.push_back(d);
      if (m_diffs.size() > DEPTH) void'(m_diffs.pop_front());
      m_prev = v;
      if (m_diffs.size() == DEPTH) begin
         s = '0;
         foreach (m_diffs[i]) s += 68'(m_diffs[i]);
         q = s / DEPTH_S;
         if (s < 0 && (s % DEPTH_S) != 0) q = q - 68'sd1;   // floor, not trunc
         d_out     = q[N-1:0];
         valid_out = 1'b1;
      end else begin
         d_out     = '0;
         valid_out = 1'b0;
      end
   endtask

   function automatic logic [N-1:0] next_val(input int mode, input int k,
                                             input logic [N-1:0] prev);
      case (mode)
         0: return prev + FIXED_POINT_SCALE;
         1: return (k <= DEPTH) ? 64'd5000 : 64'd5400;
         2: return prev - 64'd250;
         3: return prev - ((k % 4 == 0) ? 64'd2 : 64'd1);
         4: return (k == 1) ? '1 : prev - 64'd3;
         5: return ($urandom_range(0, 1) == 1) ? {$urandom, $urandom}
                   : prev + 64'($urandom_range(0, 100000)) - 64'd50000;
         default: return prev + 64'($urandom_range(0, 2000)) - 64'd1000;
      endcase
   endfunction

   // ---------------- driver ----------------
   task automatic run_session(input int mode, input logic [N-1:0] v0,
                              input int nticks, input bit do_stop);
      logic [N-1:0] v, d;
      logic         vl;
      @(negedge clk);
      start = 1'b1;
      sig   = v0;
      m_prev = v0;
      m_diffs.delete();
      m_ovf = 1'b0;
      sb.push_back(exp_t'{cyc + 1, '0, 1'b0, 1'b0});
      for (int k = 1; k <= nticks; k++) begin
         repeat (SAMPLE_CYCLES - 1) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) sig = {$urandom, $urandom};
         end
         @(negedge clk);
         v   = next_val(mode, k, m_prev);
         sig = v;
         model_tick(v, d, vl);
         sb.push_back(exp_t'{cyc + 1, d, vl, m_ovf});
      end
      repeat (3) @(negedge clk);
      if (do_stop) begin
         start = 1'b0;
         @(negedge clk);
         check("stop_derivative", derivative, '0);
         check("stop_valid", 64'(derivative_valid), 64'd0);
         check("stop_overflow_kept", 64'(overflow), 64'(m_ovf));
      end
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sample_tick) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
            end else begin
               e = sb.pop_front();
               check("tick_cycle", 64'(cyc), 64'(e.cyc));
               @(negedge clk);
               check("derivative", derivative, e.deriv);
               check("derivative_valid", 64'(derivative_valid), 64'(e.valid));
               check("overflow", 64'(overflow), 64'(e.ovf));
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      #1;
      check("reset_derivative", derivative, '0);
      check("reset_valid", 64'(derivative_valid), 64'd0);
      check("reset_tick", 64'(sample_tick), 64'd0);
      check("reset_overflow", 64'(overflow), 64'd0);
      repeat (3) @(negedge clk);
      resetb = 1'b1;
      repeat (20) @(negedge clk);            // start low: no ticks allowed

      run_session(0, 64'($urandom), 8, 1'b1);          // ramp 1e9 per tick
      run_session(1, 64'd5000, 10, 1'b1);              // step 5000 -> 5400
      run_session(2, 64'd1_000_000, 6, 1'b1);          // -250 per tick
      run_session(3, 64'd1_000_000, 6, 1'b1);          // 1,1,1,2 -> floor -2
      run_session(4, 64'd0, 5, 1'b1);                  // saturation, sticky
      run_session(6, 64'd77_000, 2, 1'b1);             // stop mid-FILL
      run_session(6, 64'd77_000, 6, 1'b1);             // full refill needed
      run_session(5, {$urandom, $urandom}, 10, 1'b1);
      run_session(5, {$urandom, $urandom}, 10, 1'b1);

      // Asynchronous reset while RUN holds a valid average.
      run_session(0, 64'd123, 6, 1'b0);
      repeat (10) @(negedge clk);
      #2;
      resetb = 1'b0;
      start  = 1'b0;
      #1;
      check("async_derivative", derivative, '0);
      check("async_valid", 64'(derivative_valid), 64'd0);
      check("async_tick", 64'(sample_tick), 64'd0);
      check("async_overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      resetb = 1'b1;
      repeat (120) @(negedge clk);           // no tick without start

      run_session(6, 64'd500_000, 5, 1'b1);
      repeat (5) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
